mem_access_unit: RTL

//  MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide, big-endian DM.

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word accesses onto a word-wide big-endian data memory.
// Optional MISALIGN_TRAP_EN: trap misaligned/out-of-range requests instead of forcing alignment.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    output logic        o_dm_read,
    output logic        o_dm_write,
    input  logic [31:0] i_dm_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;

    logic        w_accept;
    logic        w_is_word;
    logic        w_is_half;
    logic [1:0]  w_off;
    logic        w_acc_err;

    assign w_accept  = (r_state == StIdle) && i_req;
    assign w_is_word = i_size[1];
    assign w_is_half = (i_size == 2'b01);
    // Lane offset with alignment forced; trapped requests never use it.
    assign w_off     = w_is_word ? 2'b00 : (w_is_half ? {i_addr[1], 1'b0} : i_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
    logic r_err;
    assign w_acc_err = (w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00))
                     || (i_addr > (32'(MEM_BYTES) - 32'd4));
    assign o_err     = (r_state == StResp) && r_err;
`else
    assign w_acc_err = 1'b0;
    assign o_err     = 1'b0;
`endif

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        if (size[1]) begin
            load_ext = word;
        end else if (size == 2'b01) begin
            load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
        end else begin
            load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (size == 2'b01) begin
            if (off[1]) m[15:0] = wd;
            else        m[31:16] = wd;
        end else begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end
        merge = m;
    endfunction

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    if (w_acc_err)              w_state_d = StResp;
                    else if (i_we && w_is_word) w_state_d = StWr;
                    else                        w_state_d = StRd;
                end
            end
            StRd:    w_state_d = r_we ? StWr : StResp;
            StWr:    w_state_d = StResp;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= 16'h0000;
            r_rdata    <= 32'h0;
            r_dm_addr  <= 32'h0;
            r_dm_wdata <= 32'h0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_we    <= i_we;
                r_size  <= i_size;
                r_uns   <= i_uns;
                r_off   <= w_off;
                r_wdata <= i_wdata[15:0];
                if (w_acc_err) begin
                    r_rdata <= 32'h0;
                end else begin
                    r_dm_addr <= {i_addr[31:2], 2'b00};
                    if (i_we && w_is_word) r_dm_wdata <= i_wdata;
                end
            end
            // Word captured at the end of RD feeds either the merge or the load result.
            if (r_state == StRd) begin
                if (r_we) r_dm_wdata <= merge(i_dm_rdata, r_off, r_size, r_wdata);
                else      r_rdata    <= load_ext(i_dm_rdata, r_off, r_size, r_uns);
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)         r_err <= 1'b0;
        else if (w_accept) r_err <= w_acc_err;
    end
`endif

    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StResp);
    assign o_rdata    = r_rdata;
    assign o_dm_addr  = r_dm_addr;
    assign o_dm_wdata = r_dm_wdata;
    assign o_dm_read  = (r_state == StRd);
    assign o_dm_write = (r_state == StWr) && !i_rst;

endmodule
